// File: rtl/riscv_core_pipe_sched_if.sv
// Scheduler <-> datapath control bundle: D-stage decode fields, X-stage
// redirect, muldiv and data-memory handshakes, and the stage-control outputs.
interface riscv_core_pipe_sched_if;
    // Decode fields of the instruction currently in D
    logic       rs1_en_Dhl;
    logic       rs2_en_Dhl;
    logic [4:0] rs1_Dhl;
    logic [4:0] rs2_Dhl;
    logic       rd_en_Dhl;
    logic [4:0] rd_Dhl;
    logic       is_load_Dhl;
    logic       is_muldiv_Dhl;
    // Branch/jump resolution in X
    logic       redirect_Xhl;
    logic [1:0] redirect_sel_Xhl;
    // Handshakes and status from the datapath
    logic       muldivreq_rdy;
    logic       muldivresp_val;
    logic       dmemresp_val;
    logic       csr_stall_Whl;
    // Stage control generated by the scheduler
    logic [1:0] pc_mux_sel_Phl;
    logic       stall_Fhl;
    logic       stall_Dhl;
    logic       stall_Xhl;
    logic       stall_Mhl;
    logic       stall_Whl;
    logic       val_Xhl;
    logic       val_Mhl;
    logic       val_Whl;
    logic       muldivreq_val;
    logic       muldivresp_rdy;
    logic       dmemresp_queue_en_Mhl;
    logic       dmemresp_queue_val_Mhl;
    logic       rf_wen_Whl;
    logic [4:0] rf_waddr_Whl;

    // Scheduler side: consumes decode/status, drives stage control
    modport master (
        input  rs1_en_Dhl, rs2_en_Dhl, rs1_Dhl, rs2_Dhl, rd_en_Dhl, rd_Dhl,
        input  is_load_Dhl, is_muldiv_Dhl, redirect_Xhl, redirect_sel_Xhl,
        input  muldivreq_rdy, muldivresp_val, dmemresp_val, csr_stall_Whl,
        output pc_mux_sel_Phl, stall_Fhl, stall_Dhl, stall_Xhl, stall_Mhl, stall_Whl,
        output val_Xhl, val_Mhl, val_Whl, muldivreq_val, muldivresp_rdy,
        output dmemresp_queue_en_Mhl, dmemresp_queue_val_Mhl, rf_wen_Whl, rf_waddr_Whl
    );

    // Datapath side: the mirror image
    modport slave (
        output rs1_en_Dhl, rs2_en_Dhl, rs1_Dhl, rs2_Dhl, rd_en_Dhl, rd_Dhl,
        output is_load_Dhl, is_muldiv_Dhl, redirect_Xhl, redirect_sel_Xhl,
        output muldivreq_rdy, muldivresp_val, dmemresp_val, csr_stall_Whl,
        input  pc_mux_sel_Phl, stall_Fhl, stall_Dhl, stall_Xhl, stall_Mhl, stall_Whl,
        input  val_Xhl, val_Mhl, val_Whl, muldivreq_val, muldivresp_rdy,
        input  dmemresp_queue_en_Mhl, dmemresp_queue_val_Mhl, rf_wen_Whl, rf_waddr_Whl
    );
endinterface

// File: rtl/riscv_core_pipe_sched.sv
// Pipeline scheduler for the 5-stage core: tracks stage valids and producer
// tags, builds the back-to-front stall chain, inserts bubbles and squashes,
// selects the PC source and sequences the muldiv / load-response handshakes.
module riscv_core_pipe_sched #(
    parameter logic [1:0] RESET_SEL = 2'd0
) (
    input logic                     clk,
    input logic                     reset,
    riscv_core_pipe_sched_if.master bus
);

    // val_f_q marks that a fetch has been issued since reset release
    logic       val_f_q, val_f_d;
    logic       val_d_q, val_d_d;
    logic       val_x_q, val_x_d;
    logic       val_m_q, val_m_d;
    logic       val_w_q, val_w_d;
    logic       rd_en_x_q, rd_en_x_d, ld_x_q, ld_x_d, md_x_q, md_x_d;
    logic [4:0] rd_x_q, rd_x_d;
    logic       rd_en_m_q, rd_en_m_d, ld_m_q, ld_m_d;
    logic [4:0] rd_m_q, rd_m_d;
    logic       rd_en_w_q, rd_en_w_d;
    logic [4:0] rd_w_q, rd_w_d;
    logic       issued_q, issued_d;
    logic       qval_q, qval_d;

    logic stall_w, stall_m, stall_x, stall_d;
    logic redir, raw, hz_rs1, hz_rs2;
    logic mdreq_val, mdresp_rdy, q_en;

    // A source conflicts with any live in-flight producer of the same nonzero register
    function automatic logic src_hit(
        input logic en, input logic [4:0] idx,
        input logic vx, input logic ex, input logic [4:0] rx,
        input logic vm, input logic em, input logic [4:0] rm,
        input logic vw, input logic ew, input logic [4:0] rw
    );
        return en && (idx != 5'd0) &&
               ((vx && ex && (rx == idx)) ||
                (vm && em && (rm == idx)) ||
                (vw && ew && (rw == idx)));
    endfunction

    // Stall chain resolved from W back to D, plus redirect and handshake qualifiers
    always_comb begin
        stall_w    = val_w_q & bus.csr_stall_Whl;
        stall_m    = stall_w | (val_m_q & ld_m_q & ~bus.dmemresp_val & ~qval_q);
        mdresp_rdy = val_x_q & md_x_q & ~stall_m;
        stall_x    = stall_m | (val_x_q & md_x_q & ~(bus.muldivresp_val & mdresp_rdy));
        redir      = val_x_q & bus.redirect_Xhl & ~stall_x;
        hz_rs1     = src_hit(bus.rs1_en_Dhl, bus.rs1_Dhl,
                             val_x_q, rd_en_x_q, rd_x_q,
                             val_m_q, rd_en_m_q, rd_m_q,
                             val_w_q, rd_en_w_q, rd_w_q);
        hz_rs2     = src_hit(bus.rs2_en_Dhl, bus.rs2_Dhl,
                             val_x_q, rd_en_x_q, rd_x_q,
                             val_m_q, rd_en_m_q, rd_m_q,
                             val_w_q, rd_en_w_q, rd_w_q);
        raw        = val_d_q & (hz_rs1 | hz_rs2);
        // A redirect squashes the dependent instruction anyway, so it overrides RAW
        stall_d    = stall_x | (raw & ~redir);
        mdreq_val  = val_x_q & md_x_q & ~issued_q;
        q_en       = val_m_q & ld_m_q & bus.dmemresp_val & stall_w & ~qval_q;
    end

    // Next-state: advancing stages take upstream data, bubbling when upstream is stalled
    always_comb begin
        val_f_d   = 1'b1;
        val_d_d   = val_d_q;
        val_x_d   = val_x_q;
        rd_en_x_d = rd_en_x_q;
        rd_x_d    = rd_x_q;
        ld_x_d    = ld_x_q;
        md_x_d    = md_x_q;
        val_m_d   = val_m_q;
        rd_en_m_d = rd_en_m_q;
        rd_m_d    = rd_m_q;
        ld_m_d    = ld_m_q;
        val_w_d   = val_w_q;
        rd_en_w_d = rd_en_w_q;
        rd_w_d    = rd_w_q;
        issued_d  = issued_q;
        qval_d    = qval_q;

        if (!stall_d) begin
            val_d_d = val_f_q & ~redir;
        end
        if (!stall_x) begin
            val_x_d   = val_d_q & ~stall_d & ~redir;
            rd_en_x_d = bus.rd_en_Dhl;
            rd_x_d    = bus.rd_Dhl;
            ld_x_d    = bus.is_load_Dhl;
            md_x_d    = bus.is_muldiv_Dhl;
        end
        if (!stall_m) begin
            val_m_d   = val_x_q & ~stall_x;
            rd_en_m_d = rd_en_x_q;
            rd_m_d    = rd_x_q;
            ld_m_d    = ld_x_q;
        end
        if (!stall_w) begin
            val_w_d   = val_m_q & ~stall_m;
            rd_en_w_d = rd_en_m_q;
            rd_w_d    = rd_m_q;
        end

        // A request is accepted once per muldiv; leaving X rearms it
        if (!stall_x) begin
            issued_d = 1'b0;
        end else if (mdreq_val && bus.muldivreq_rdy) begin
            issued_d = 1'b1;
        end

        // Held load response lives until the load leaves M
        if (!stall_m) begin
            qval_d = 1'b0;
        end else if (q_en) begin
            qval_d = 1'b1;
        end
    end

    // State registers; reset discards every in-flight instruction and handshake
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            val_f_q   <= 1'b0;
            val_d_q   <= 1'b0;
            val_x_q   <= 1'b0;
            val_m_q   <= 1'b0;
            val_w_q   <= 1'b0;
            rd_en_x_q <= 1'b0;
            rd_x_q    <= 5'd0;
            ld_x_q    <= 1'b0;
            md_x_q    <= 1'b0;
            rd_en_m_q <= 1'b0;
            rd_m_q    <= 5'd0;
            ld_m_q    <= 1'b0;
            rd_en_w_q <= 1'b0;
            rd_w_q    <= 5'd0;
            issued_q  <= 1'b0;
            qval_q    <= 1'b0;
        end else begin
            val_f_q   <= val_f_d;
            val_d_q   <= val_d_d;
            val_x_q   <= val_x_d;
            val_m_q   <= val_m_d;
            val_w_q   <= val_w_d;
            rd_en_x_q <= rd_en_x_d;
            rd_x_q    <= rd_x_d;
            ld_x_q    <= ld_x_d;
            md_x_q    <= md_x_d;
            rd_en_m_q <= rd_en_m_d;
            rd_m_q    <= rd_m_d;
            ld_m_q    <= ld_m_d;
            rd_en_w_q <= rd_en_w_d;
            rd_w_q    <= rd_w_d;
            issued_q  <= issued_d;
            qval_q    <= qval_d;
        end
    end

    assign bus.pc_mux_sel_Phl         = redir ? bus.redirect_sel_Xhl : RESET_SEL;
    assign bus.stall_Fhl              = stall_d;
    assign bus.stall_Dhl              = stall_d;
    assign bus.stall_Xhl              = stall_x;
    assign bus.stall_Mhl              = stall_m;
    assign bus.stall_Whl              = stall_w;
    assign bus.val_Xhl                = val_x_q;
    assign bus.val_Mhl                = val_m_q;
    assign bus.val_Whl                = val_w_q;
    assign bus.muldivreq_val          = mdreq_val;
    assign bus.muldivresp_rdy         = mdresp_rdy;
    assign bus.dmemresp_queue_en_Mhl  = q_en;
    assign bus.dmemresp_queue_val_Mhl = qval_q;
    assign bus.rf_wen_Whl             = val_w_q & rd_en_w_q & (rd_w_q != 5'd0) & ~stall_w;
    assign bus.rf_waddr_Whl           = rd_w_q;

endmodule

// File: tb/tb_riscv_core_pipe_sched.sv
// Directed bench for riscv_core_pipe_sched: reset, independent ALU flow,
// RAW stalls, taken redirect, muldiv handshake, held load response and
// asynchronous reset during a muldiv wait.
module tb_riscv_core_pipe_sched;

    localparam logic [1:0] RS = 2'd3;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   acc;

    riscv_core_pipe_sched_if bus ();

    riscv_core_pipe_sched #(.RESET_SEL(RS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count accepted muldiv requests, sampled mid-cycle
    always @(negedge clk) begin
        if (reset && bus.muldivreq_val && bus.muldivreq_rdy) acc++;
    end

    // A new memory response must never arrive while one is already held
    always @(negedge clk) begin
        if (reset) begin
            assert (!(bus.dmemresp_val && bus.dmemresp_queue_val_Mhl)) else begin
                failures++;
                $error("FAIL dmem_while_qval observed=1 expected=0");
            end
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic dec(input logic r1e, input logic [4:0] r1, input logic r2e, input logic [4:0] r2,
                       input logic rde, input logic [4:0] rd, input logic ld, input logic md);
        bus.rs1_en_Dhl    = r1e;
        bus.rs1_Dhl       = r1;
        bus.rs2_en_Dhl    = r2e;
        bus.rs2_Dhl       = r2;
        bus.rd_en_Dhl     = rde;
        bus.rd_Dhl        = rd;
        bus.is_load_Dhl   = ld;
        bus.is_muldiv_Dhl = md;
    endtask

    task automatic nop();
        dec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_pc"},     {6'd0, bus.pc_mux_sel_Phl}, {6'd0, RS});
        chk({pfx, "_stallF"}, {7'd0, bus.stall_Fhl}, 8'd0);
        chk({pfx, "_stallD"}, {7'd0, bus.stall_Dhl}, 8'd0);
        chk({pfx, "_stallX"}, {7'd0, bus.stall_Xhl}, 8'd0);
        chk({pfx, "_stallM"}, {7'd0, bus.stall_Mhl}, 8'd0);
        chk({pfx, "_stallW"}, {7'd0, bus.stall_Whl}, 8'd0);
        chk({pfx, "_valX"},   {7'd0, bus.val_Xhl}, 8'd0);
        chk({pfx, "_valM"},   {7'd0, bus.val_Mhl}, 8'd0);
        chk({pfx, "_valW"},   {7'd0, bus.val_Whl}, 8'd0);
        chk({pfx, "_mdreq"},  {7'd0, bus.muldivreq_val}, 8'd0);
        chk({pfx, "_mdrdy"},  {7'd0, bus.muldivresp_rdy}, 8'd0);
        chk({pfx, "_qen"},    {7'd0, bus.dmemresp_queue_en_Mhl}, 8'd0);
        chk({pfx, "_qval"},   {7'd0, bus.dmemresp_queue_val_Mhl}, 8'd0);
        chk({pfx, "_wen"},    {7'd0, bus.rf_wen_Whl}, 8'd0);
    endtask

    task automatic chk_wb(input string tag, input logic wen, input logic [4:0] addr);
        chk({tag, "_wen"}, {7'd0, bus.rf_wen_Whl}, {7'd0, wen});
        if (wen) chk({tag, "_waddr"}, {3'd0, bus.rf_waddr_Whl}, {3'd0, addr});
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        acc      = 0;
        reset    = 1'b1;
        nop();
        bus.redirect_Xhl     = 1'b0;
        bus.redirect_sel_Xhl = 2'd0;
        bus.muldivreq_rdy    = 1'b0;
        bus.muldivresp_val   = 1'b0;
        bus.dmemresp_val     = 1'b0;
        bus.csr_stall_Whl    = 1'b0;

        // Reset asserted before any clock edge
        #1 reset = 1'b0;
        #2;
        chk_reset_outputs("rst");
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;

        // Independent ALU stream: first write lands 5 edges after release
        settle(); chk("c0_valX", {7'd0, bus.val_Xhl}, 8'd0);
        tick(); settle(); chk_wb("c1", 1'b0, 5'd0);
        tick(); dec(1, 5'd20, 1, 5'd21, 1, 5'd1, 0, 0); settle();
        chk("c2_valX", {7'd0, bus.val_Xhl}, 8'd0);
        tick(); dec(1, 5'd20, 1, 5'd21, 1, 5'd2, 0, 0); settle();
        chk("c3_valX", {7'd0, bus.val_Xhl}, 8'd1); chk_wb("c3", 1'b0, 5'd0);
        tick(); dec(1, 5'd20, 1, 5'd21, 1, 5'd3, 0, 0); settle();
        chk("c4_valM", {7'd0, bus.val_Mhl}, 8'd1); chk_wb("c4", 1'b0, 5'd0);
        tick(); dec(1, 5'd20, 1, 5'd21, 1, 5'd4, 0, 0); settle();
        chk("c5_valW", {7'd0, bus.val_Whl}, 8'd1); chk_wb("c5", 1'b1, 5'd1);
        chk("c5_stallD", {7'd0, bus.stall_Dhl}, 8'd0);
        tick(); dec(1, 5'd20, 1, 5'd21, 1, 5'd7, 0, 0); settle(); chk_wb("c6", 1'b1, 5'd2);
        tick(); nop(); settle(); chk_wb("c7", 1'b1, 5'd3);
        tick(); settle(); chk_wb("c8", 1'b1, 5'd4);
        tick(); settle(); chk_wb("c9", 1'b1, 5'd7);
        chk("c9_stallF", {7'd0, bus.stall_Fhl}, 8'd0);
        tick(); settle(); chk_wb("c10", 1'b0, 5'd0);

        // RAW: add x5 then add x6,x5,x1 -> three D stalls, three X bubbles
        tick(); dec(1, 5'd20, 0, 5'd0, 1, 5'd5, 0, 0); settle();
        chk("raw0_stallD", {7'd0, bus.stall_Dhl}, 8'd0);
        tick(); dec(1, 5'd5, 1, 5'd1, 1, 5'd6, 0, 0); settle();
        chk("raw1_stallD", {7'd0, bus.stall_Dhl}, 8'd1);
        chk("raw1_stallF", {7'd0, bus.stall_Fhl}, 8'd1);
        chk("raw1_stallX", {7'd0, bus.stall_Xhl}, 8'd0);
        tick(); settle();
        chk("raw2_stallD", {7'd0, bus.stall_Dhl}, 8'd1);
        chk("raw2_valX", {7'd0, bus.val_Xhl}, 8'd0);
        tick(); settle();
        chk("raw3_stallD", {7'd0, bus.stall_Dhl}, 8'd1);
        chk("raw3_valX", {7'd0, bus.val_Xhl}, 8'd0);
        chk_wb("raw3", 1'b1, 5'd5);
        tick(); settle();
        chk("raw4_stallD", {7'd0, bus.stall_Dhl}, 8'd0);
        chk("raw4_valX", {7'd0, bus.val_Xhl}, 8'd0);
        // Producer of x0 followed by a reader of x0: no stall, no write
        tick(); dec(0, 5'd0, 0, 5'd0, 1, 5'd0, 0, 0); settle();
        chk("raw5_valX", {7'd0, bus.val_Xhl}, 8'd1);
        chk("raw5_stallD", {7'd0, bus.stall_Dhl}, 8'd0);
        tick(); dec(1, 5'd0, 1, 5'd0, 0, 5'd0, 0, 0); settle();
        chk("x0_stallD", {7'd0, bus.stall_Dhl}, 8'd0);
        tick(); nop(); settle(); chk_wb("raw7", 1'b1, 5'd6);
        tick(); settle();
        chk("x0_valW", {7'd0, bus.val_Whl}, 8'd1); chk_wb("x0", 1'b0, 5'd0);

        // Taken branch with a RAW-dependent instruction behind it
        tick(); dec(0, 5'd0, 0, 5'd0, 1, 5'd14, 0, 0); settle();
        tick(); dec(1, 5'd20, 1, 5'd21, 0, 5'd0, 0, 0); settle();
        tick(); dec(1, 5'd14, 0, 5'd0, 1, 5'd8, 0, 0);
        bus.redirect_Xhl = 1'b1; bus.redirect_sel_Xhl = 2'd1; settle();
        chk("br1_pc", {6'd0, bus.pc_mux_sel_Phl}, 8'd1);
        chk("br1_stallD", {7'd0, bus.stall_Dhl}, 8'd0);
        chk("br1_stallX", {7'd0, bus.stall_Xhl}, 8'd0);
        tick(); dec(1, 5'd14, 0, 5'd0, 1, 5'd9, 0, 0);
        bus.redirect_Xhl = 1'b0; bus.redirect_sel_Xhl = 2'd0; settle();
        chk("br2_pc", {6'd0, bus.pc_mux_sel_Phl}, {6'd0, RS});
        chk("br2_valX", {7'd0, bus.val_Xhl}, 8'd0);
        chk("br2_stallD", {7'd0, bus.stall_Dhl}, 8'd0);
        chk_wb("br2", 1'b1, 5'd14);
        tick(); dec(0, 5'd0, 0, 5'd0, 1, 5'd10, 0, 0); settle();
        chk("br3_valX", {7'd0, bus.val_Xhl}, 8'd0); chk_wb("br3", 1'b0, 5'd0);
        tick(); nop(); settle();
        chk("br4_valX", {7'd0, bus.val_Xhl}, 8'd1); chk_wb("br4", 1'b0, 5'd0);
        tick(); settle(); chk_wb("br5", 1'b0, 5'd0);
        tick(); settle(); chk_wb("br6", 1'b1, 5'd10);

        // Muldiv: request refused twice, accepted, response 4 cycles later
        tick(); dec(0, 5'd0, 0, 5'd0, 1, 5'd11, 0, 1); settle();
        chk("md0_stallX", {7'd0, bus.stall_Xhl}, 8'd0);
        tick(); nop(); settle();
        chk("md1_req", {7'd0, bus.muldivreq_val}, 8'd1);
        chk("md1_stallX", {7'd0, bus.stall_Xhl}, 8'd1);
        chk("md1_stallD", {7'd0, bus.stall_Dhl}, 8'd1);
        chk("md1_resprdy", {7'd0, bus.muldivresp_rdy}, 8'd1);
        tick(); settle();
        chk("md2_req", {7'd0, bus.muldivreq_val}, 8'd1);
        chk("md2_valM", {7'd0, bus.val_Mhl}, 8'd0);
        tick(); bus.muldivreq_rdy = 1'b1; settle();
        chk("md3_req", {7'd0, bus.muldivreq_val}, 8'd1);
        tick(); settle();
        chk("md4_req", {7'd0, bus.muldivreq_val}, 8'd0);
        chk("md4_stallX", {7'd0, bus.stall_Xhl}, 8'd1);
        tick(); settle();
        chk("md5_req", {7'd0, bus.muldivreq_val}, 8'd0);
        chk("md5_stallX", {7'd0, bus.stall_Xhl}, 8'd1);
        tick(); settle();
        chk("md6_stallX", {7'd0, bus.stall_Xhl}, 8'd1);
        tick(); bus.muldivresp_val = 1'b1; settle();
        chk("md7_stallX", {7'd0, bus.stall_Xhl}, 8'd0);
        chk("md7_resprdy", {7'd0, bus.muldivresp_rdy}, 8'd1);
        chk("md7_stallD", {7'd0, bus.stall_Dhl}, 8'd0);
        tick(); bus.muldivresp_val = 1'b0; bus.muldivreq_rdy = 1'b0; settle();
        chk("md8_req", {7'd0, bus.muldivreq_val}, 8'd0);
        chk("md8_valX", {7'd0, bus.val_Xhl}, 8'd1);
        chk("md8_stallX", {7'd0, bus.stall_Xhl}, 8'd0);
        tick(); settle(); chk_wb("md9", 1'b1, 5'd11);
        chk("md_accepts", acc[7:0], 8'd1);

        // Load whose response arrives while W is held by a CSR stall
        tick(); dec(0, 5'd0, 0, 5'd0, 1, 5'd12, 1, 0); settle();
        tick(); nop(); settle();
        tick(); bus.csr_stall_Whl = 1'b1; settle();
        chk("ld2_valW", {7'd0, bus.val_Whl}, 8'd1);
        chk("ld2_stallW", {7'd0, bus.stall_Whl}, 8'd1);
        chk("ld2_stallM", {7'd0, bus.stall_Mhl}, 8'd1);
        chk("ld2_stallD", {7'd0, bus.stall_Dhl}, 8'd1);
        chk("ld2_qen", {7'd0, bus.dmemresp_queue_en_Mhl}, 8'd0);
        tick(); settle();
        chk("ld3_qen", {7'd0, bus.dmemresp_queue_en_Mhl}, 8'd0);
        tick(); bus.dmemresp_val = 1'b1; settle();
        chk("ld4_qen", {7'd0, bus.dmemresp_queue_en_Mhl}, 8'd1);
        chk("ld4_stallM", {7'd0, bus.stall_Mhl}, 8'd1);
        tick(); bus.dmemresp_val = 1'b0; bus.csr_stall_Whl = 1'b0; settle();
        chk("ld5_qen", {7'd0, bus.dmemresp_queue_en_Mhl}, 8'd0);
        chk("ld5_qval", {7'd0, bus.dmemresp_queue_val_Mhl}, 8'd1);
        chk("ld5_stallM", {7'd0, bus.stall_Mhl}, 8'd0);
        chk("ld5_stallW", {7'd0, bus.stall_Whl}, 8'd0);
        tick(); settle();
        chk("ld6_qval", {7'd0, bus.dmemresp_queue_val_Mhl}, 8'd0);
        chk_wb("ld6", 1'b1, 5'd12);

        // Asynchronous reset in the middle of a muldiv wait
        tick(); dec(0, 5'd0, 0, 5'd0, 1, 5'd13, 0, 1); settle();
        tick(); nop(); settle();
        chk("ar_req", {7'd0, bus.muldivreq_val}, 8'd1);
        chk("ar_stallX", {7'd0, bus.stall_Xhl}, 8'd1);
        #2;
        reset = 1'b0;
        bus.muldivresp_val = 1'b1;
        #1;
        chk_reset_outputs("ar");
        tick();
        tick();
        reset = 1'b1;
        settle();
        chk("ar_rel_valX", {7'd0, bus.val_Xhl}, 8'd0);
        chk("ar_rel_resprdy", {7'd0, bus.muldivresp_rdy}, 8'd0);
        chk("ar_rel_stallX", {7'd0, bus.stall_Xhl}, 8'd0);
        bus.muldivresp_val = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/riscv_core_pipe_sched.md
# riscv_core_pipe_sched

Pipeline scheduler for the 5-stage RISCV core. It owns the per-stage valid bits and the producer register tags, and from them generates the `stall_*hl` vector, bubbles and squashes, and the PC-mux select. It also sequences the muldiv valid/ready handshake and the data-memory response holding register. It sits beside the core datapath: decode fields come in from the control decoder, and the datapath's stage registers are gated by this block's outputs.

## Interface
Parameters:
- `RESET_SEL`, default 2'd0: value driven on `pc_mux_sel_Phl` when no redirect is pending.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rs1_en_Dhl`, `rs2_en_Dhl`  in  1  D-stage instruction reads rs1 / rs2.
- `rs1_Dhl`, `rs2_Dhl`  in  5  D-stage source register indices.
- `rd_en_Dhl`  in  1  D-stage instruction writes rd.
- `rd_Dhl`  in  5  D-stage destination register index.
- `is_load_Dhl`, `is_muldiv_Dhl`  in  1  D-stage instruction class.
- `redirect_Xhl`  in  1  X-stage branch taken, or jal/jalr.
- `redirect_sel_Xhl`  in  2  target select: 1 branch, 2 jal, 3 jalr.
- `muldivreq_rdy`, `muldivresp_val`  in  1  muldiv handshake from the datapath.
- `dmemresp_val`  in  1  data-memory response valid in M.
- `csr_stall_Whl`  in  1  W cannot retire this cycle.
- `pc_mux_sel_Phl`  out  2  PC mux select.
- `stall_Fhl`, `stall_Dhl`, `stall_Xhl`, `stall_Mhl`, `stall_Whl`  out  1  hold the corresponding stage register.
- `val_Xhl`, `val_Mhl`, `val_Whl`  out  1  stage holds a live instruction.
- `muldivreq_val`, `muldivresp_rdy`  out  1  muldiv handshake to the datapath.
- `dmemresp_queue_en_Mhl`, `dmemresp_queue_val_Mhl`  out  1  response-holding-register load enable / select.
- `rf_wen_Whl`  out  1  register file write enable.
- `rf_waddr_Whl`  out  5  register file write address.

## Operation
- Per-stage state for D, X, M and W: `val`, plus `rd_en`, `rd`, `is_load`, `is_muldiv` for X/M/W. Two further flags: `issued` (muldiv request accepted) and `qval` (response held).
- Stall chain, evaluated in this order:
  - `stall_W = val_W & csr_stall_Whl`.
  - `stall_M = stall_W | (val_M & is_load_M & !dmemresp_val & !qval)`.
  - `stall_X = stall_M | (val_X & is_muldiv_X & !(muldivresp_val & muldivresp_rdy))`.
  - `stall_D = stall_X | (raw & !redir)`.
  - `stall_F = stall_D`.
- Definitions used above:
  - `redir = val_X & redirect_Xhl & !stall_X`.
  - `raw = val_D & (rs1 hazard | rs2 hazard)`. A source hazards when its enable is set, its index is nonzero, and it equals `rd` of any valid X, M or W stage with `rd_en` set.
  - The datapath has no bypass, so every RAW dependence stalls D until the producer has left W.
- Bubbles: a stage that advances while its upstream neighbour is stalled loads `val=0`. For example, `stall_D & !stall_X` leaves X invalid next cycle.
- Redirect:
  - `pc_mux_sel_Phl = redir ? redirect_sel_Xhl : RESET_SEL`.
  - On `redir`, D and X load `val=0`; this squashes the two younger instructions.
  - Redirect overrides a RAW stall in D.
- `val_D` loads 1 on every non-stalled edge without `redir`, so the first instruction becomes valid in D on the second edge after reset release.
- Muldiv:
  - `muldivreq_val = val_X & is_muldiv_X & !issued`.
  - `issued` sets on `muldivreq_val & muldivreq_rdy` and clears when X advances.
  - `muldivresp_rdy = val_X & is_muldiv_X & !stall_M`.
- Load response holding:
  - `dmemresp_queue_en_Mhl = val_M & is_load_M & dmemresp_val & stall_W & !qval`.
  - `qval` sets on that enable and clears when M advances.
  - `dmemresp_queue_val_Mhl = qval`.
- Writeback:
  - `rf_wen_Whl = val_W & rd_en_W & (rd_W != 0) & !stall_W`.
  - `rf_waddr_Whl = rd_W`.

## Timing
- Reset (asynchronous, `reset=0`): all `val` bits, `issued` and `qval` clear.
  - All outputs read 0: stalls, `muldivreq_val`, `muldivresp_rdy`, queue signals, `rf_wen_Whl`.
  - `pc_mux_sel_Phl` reads `RESET_SEL`.
- Reset asserted mid-operation discards all in-flight instructions and any pending muldiv; the response from an abandoned muldiv is ignored.
- All outputs are combinational from state plus same-cycle inputs; there are no combinational paths from outputs back to inputs.
- Latencies:
  - Taken redirect costs 2 bubbles.
  - Back-to-back dependence costs 3 stall cycles.
  - A load costs 1 + the memory wait cycles in M.
  - A muldiv occupies X until the response handshake completes.
- Simultaneous events:
  - Redirect and RAW in the same cycle: redirect wins.
  - Redirect while X is stalled: deferred until X advances, with the select held.
  - `dmemresp_val` while `qval=1`: not permitted; a bench assertion checks it.
- `rd = 0` never creates a hazard and never produces a write.

## Test plan
- Reset release, then 5 independent ALU instructions → all stalls 0; the first `rf_wen_Whl=1` occurs 5 edges after reset release; `rf_waddr_Whl` follows the `rd` sequence.
- `add x5` then `add x6,x5,x1` → `stall_Dhl=1` for exactly 3 cycles; X gets 3 bubbles; with `rs1=x0` there are 0 stalls.
- Taken branch in X, `redirect_sel_Xhl=1` → `pc_mux_sel_Phl=1` for 1 cycle; `val_Xhl=0` for the 2 following cycles; the two squashed instructions never assert `rf_wen_Whl`.
- Muldiv with `muldivreq_rdy` low for 2 cycles and the response after 4 more → `muldivreq_val` high for 3 cycles then low; `stall_Xhl` high until `muldivresp_val&rdy`; exactly one request is accepted.
- Load with `dmemresp_val` after 2 cycles while `csr_stall_Whl=1` for 3 cycles → `dmemresp_queue_en_Mhl` pulses once; `dmemresp_queue_val_Mhl` stays 1 until M advances.
- Assert `reset` low during a muldiv wait → every output returns to its reset value immediately, without waiting for a clock edge.
